// File: rtl/cmd_stream_queue_if.sv
// Write-side valid/ready handshake for the command queue.
// Producer drives the master view; the queue takes the slave view.
interface cmd_stream_queue_if #(
    parameter int WIDTH = 64
);
    logic             wr_valid;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/cmd_stream_queue.sv
// Circular command queue between the command stream and the issuer, with FWFT head.
// Define CMDQ_STATS_EN to add the o_high_water occupancy statistic.
module cmd_stream_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    cmd_stream_queue_if.slave wr,
    input  logic              i_read,
    output logic [WIDTH-1:0]  o_data,
    output logic              o_fifo_empty,
    output logic              o_full,
    output logic [AW:0]       o_count,
    output logic [31:0]       o_issued,
    output logic              o_underflow
`ifdef CMDQ_STATS_EN
    ,
    output logic [AW:0]       o_high_water
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_nxt;
    logic [AW-1:0]    wr_nxt;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic [31:0]      issued;
    logic [31:0]      issued_nxt;
    logic             uflow;
    logic             uflow_nxt;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_nxt;
    logic             wr_acc;
    logic             pop;

    assign o_fifo_empty = (count == '0);
    assign o_full       = (count == FULL_CNT);
    assign wr.wr_ready  = !o_full;

    assign wr_acc = wr.wr_valid && !o_full;
    assign pop    = i_read && !o_fifo_empty;

    assign o_data      = data_q;
    assign o_count     = count;
    assign o_issued    = issued;
    assign o_underflow = uflow;

    always_comb begin
        rd_nxt     = rd_ptr;
        wr_nxt     = wr_ptr;
        count_nxt  = count;
        issued_nxt = issued;
        uflow_nxt  = uflow;
        data_nxt   = data_q;
        if (i_flush) begin
            rd_nxt     = '0;
            wr_nxt     = '0;
            count_nxt  = '0;
            issued_nxt = '0;
            uflow_nxt  = 1'b0;
            data_nxt   = '0;
        end else begin
            if (wr_acc) begin
                wr_nxt = wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_nxt     = rd_ptr + 1'b1;
                issued_nxt = issued + 32'd1;
            end
            if (i_read && o_fifo_empty) begin
                uflow_nxt = 1'b1;
            end
            unique case ({wr_acc, pop})
                2'b10:   count_nxt = count + 1'b1;
                2'b01:   count_nxt = count - 1'b1;
                default: count_nxt = count;
            endcase
            // Head slot being written this cycle is not in RAM yet: bypass.
            if (wr_acc && (wr_ptr == rd_nxt)) begin
                data_nxt = wr.wr_data;
            end else begin
                data_nxt = mem[rd_nxt];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            issued <= '0;
            uflow  <= 1'b0;
            data_q <= '0;
        end else begin
            rd_ptr <= rd_nxt;
            wr_ptr <= wr_nxt;
            count  <= count_nxt;
            issued <= issued_nxt;
            uflow  <= uflow_nxt;
            data_q <= data_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush && wr_acc) begin
            mem[wr_ptr] <= wr.wr_data;
        end
    end

`ifdef CMDQ_STATS_EN
    logic [AW:0] hw_q;
    logic [AW:0] hw_nxt;

    always_comb begin
        hw_nxt = hw_q;
        if (i_flush) begin
            hw_nxt = '0;
        end else if (count_nxt > hw_q) begin
            hw_nxt = count_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hw_q <= '0;
        end else begin
            hw_q <= hw_nxt;
        end
    end

    assign o_high_water = hw_q;
`endif

endmodule

// File: tb/tb_cmd_stream_queue.sv
// Randomized + directed bench for cmd_stream_queue against a queue-based model.
// Build with CMDQ_STATS_EN defined to also cover o_high_water.
module tb_cmd_stream_queue;
    localparam int W = 64;
    localparam int D = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         flush;
    logic         rd;
    logic [W-1:0] data;
    logic         empty;
    logic         full;
    logic [4:0]   count;
    logic [31:0]  issued;
    logic         uflow;
`ifdef CMDQ_STATS_EN
    logic [4:0]   hw;
`endif

    cmd_stream_queue_if #(.WIDTH(W)) ifc ();

    cmd_stream_queue #(.WIDTH(W), .DEPTH(D)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flush      (flush),
        .wr           (ifc),
        .i_read       (rd),
        .o_data       (data),
        .o_fifo_empty (empty),
        .o_full       (full),
        .o_count      (count),
        .o_issued     (issued),
        .o_underflow  (uflow)
`ifdef CMDQ_STATS_EN
        ,
        .o_high_water (hw)
`endif
    );

    int errs = 0;
    int checks = 0;

    // Reference model: contents as a queue, counters as plain integers.
    logic [W-1:0] mq [$];
    logic [31:0]  m_issued = 0;
    logic         m_uflow = 0;
    int           m_hw = 0;
    bit           live = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic v, input logic [W-1:0] d,
                              input logic r, input logic f,
                              input logic rs);
        int pre;
        pre = mq.size();
        if (rs || f) begin
            mq.delete();
            m_issued = 0;
            m_uflow  = 0;
            m_hw     = 0;
        end else begin
            if (r && pre == 0) m_uflow = 1;
            if (r && pre > 0) begin
                void'(mq.pop_front());
                m_issued = m_issued + 1;
            end
            if (v && pre < D) mq.push_back(d);
            if (mq.size() > m_hw) m_hw = mq.size();
        end
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] d,
                         input logic r, input logic f, input logic rs);
        ifc.wr_valid = v;
        ifc.wr_data  = d;
        rd           = r;
        flush        = f;
        rst          = rs;
        @(posedge clk);
        model_step(v, d, r, f, rs);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_flush();
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    always @(negedge clk) begin
        if (live) begin
            chk("count", 64'(count), 64'(mq.size()));
            chk("empty", 64'(empty), 64'(mq.size() == 0));
            chk("full", 64'(full), 64'(mq.size() == D));
            chk("wr_ready", 64'(ifc.wr_ready), 64'(mq.size() != D));
            chk("issued", 64'(issued), 64'(m_issued));
            chk("underflow", 64'(uflow), 64'(m_uflow));
            if (mq.size() > 0) chk("head_data", data, mq[0]);
`ifdef CMDQ_STATS_EN
            chk("high_water", 64'(hw), 64'(m_hw));
`endif
        end
    end

    bit           pv;
    logic [W-1:0] pd;

    initial begin
        ifc.wr_valid = 1'b0;
        ifc.wr_data  = '0;
        rd    = 1'b0;
        flush = 1'b0;
        rst   = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        live = 1;

        // Reset state
        chk("rst_data", data, 64'h0);
        chk("rst_empty", 64'(empty), 64'h1);
        chk("rst_ready", 64'(ifc.wr_ready), 64'h1);
        chk("rst_count", 64'(count), 64'h0);

        // Three writes, no reads
        push(64'hA1);
        chk("fwft_data", data, 64'hA1);
        chk("fwft_empty", 64'(empty), 64'h0);
        push(64'hA2);
        push(64'hA3);
        chk("three_count", 64'(count), 64'h3);
        chk("three_head", data, 64'hA1);

        // Fill, hold a 17th word while full, then free a slot
        do_flush();
        for (int i = 0; i < D; i++) push(64'(i));
        chk("fill_full", 64'(full), 64'h1);
        chk("fill_ready", 64'(ifc.wr_ready), 64'h0);
        cycle(1'b1, 64'h99, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'h99, 1'b0, 1'b0, 1'b0);
        chk("held_count", 64'(count), 64'd16);
        chk("held_head", data, 64'h0);
        cycle(1'b1, 64'h99, 1'b1, 1'b0, 1'b0);
        chk("pop_ready", 64'(ifc.wr_ready), 64'h1);
        chk("pop_head", data, 64'h1);
        cycle(1'b1, 64'h99, 1'b0, 1'b0, 1'b0);
        chk("refill_full", 64'(full), 64'h1);
        for (int i = 0; i < D - 1; i++) pop1();
        chk("tail_99", data, 64'h99);
        pop1();

        // Streaming write+pop from occupancy 5
        do_flush();
        for (int i = 0; i < 5; i++) push(64'h100 + 64'(i));
        for (int i = 0; i < 40; i++)
            cycle(1'b1, 64'h200 + 64'(i), 1'b1, 1'b0, 1'b0);
        chk("stream_count", 64'(count), 64'd5);
        chk("stream_issued", 64'(issued), 64'd40);
        chk("stream_head", data, 64'h223);

        // Underflow on empty, sticky, cleared by flush
        do_flush();
        pop1();
        chk("uflow_set", 64'(uflow), 64'h1);
        chk("uflow_count", 64'(count), 64'h0);
        idle();
        chk("uflow_sticky", 64'(uflow), 64'h1);
        cycle(1'b1, 64'h55, 1'b1, 1'b0, 1'b0);
        chk("wr_rd_empty_count", 64'(count), 64'h1);
        do_flush();
        chk("uflow_clear", 64'(uflow), 64'h0);

        // Flush with a same-cycle write drops it
        for (int i = 0; i < 7; i++) push(64'h300 + 64'(i));
        pop1();
        push(64'h307);
        cycle(1'b1, 64'h3FF, 1'b0, 1'b1, 1'b0);
        chk("flush_count", 64'(count), 64'h0);
        chk("flush_empty", 64'(empty), 64'h1);
        chk("flush_issued", 64'(issued), 64'h0);

`ifdef CMDQ_STATS_EN
        for (int i = 0; i < 9; i++) push(64'h400 + 64'(i));
        for (int i = 0; i < 4; i++) pop1();
        for (int i = 0; i < 2; i++) push(64'h500 + 64'(i));
        chk("hw_peak", 64'(hw), 64'd9);
        chk("hw_count", 64'(count), 64'd7);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("hw_reset", 64'(hw), 64'd0);
`endif

        // Randomized traffic; producer holds its word until accepted
        pv = 0;
        pd = '0;
        for (int seg = 0; seg < 12; seg++) begin
            int rate;
            rate = (seg % 3 == 0) ? 20 : ((seg % 3 == 1) ? 80 : 50);
            for (int n = 0; n < 200; n++) begin
                bit r;
                bit f;
                bit rs;
                bit acc;
                if (!pv) begin
                    pv = ($urandom_range(0, 99) < 65);
                    pd = {$urandom, $urandom};
                end
                r  = ($urandom_range(0, 99) < rate);
                f  = ($urandom_range(0, 299) == 0);
                rs = ($urandom_range(0, 599) == 0);
                acc = pv && (mq.size() < D) && !f && !rs;
                cycle(pv, pd, r, f, rs);
                if (acc || f || rs) pv = 0;
            end
        end

        idle();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
